// File: rtl/instruction_fetch_pc.sv
// instruction_fetch_pc: PC register and fetch control (run/step/stall/redirect/halt) ahead of the instruction RAM.
module instruction_fetch_pc #(
  parameter int PC_WIDTH  = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic [PC_WIDTH-1:0]  i_branch_target,
  input  logic                 i_jump,
  input  logic [PC_WIDTH-1:0]  i_jump_target,
  input  logic                 i_halt_detect,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic                 o_ram_ena,
  output logic                 o_ram_flush,
  output logic [PC_WIDTH-1:0]  o_pc_plus1,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;
  localparam logic [PC_WIDTH-1:0] MASK = PC_WIDTH'(RAM_DEPTH - 1);
  state_t r_state, w_state_nxt;
  logic r_step_pending, w_step_nxt, w_fetch, w_redir, w_stall, w_halt;
  logic [PC_WIDTH-1:0] r_pc, r_pc_plus1, w_pc_inc, w_pc_nxt, w_target;
  logic [CNT_WIDTH-1:0] r_cnt;
  always_comb begin
    w_fetch     = r_state == RUN || (r_state == STEP && r_step_pending);
    w_redir     = w_fetch && (i_jump || i_branch_taken);
    w_stall     = w_fetch && !w_redir && i_stall;
    w_halt      = w_fetch && !w_redir && !i_stall && i_halt_detect;
    o_ram_ena   = w_fetch && !w_stall;
    o_ram_flush = w_redir;
    w_target    = (i_jump ? i_jump_target : i_branch_target) & MASK;
    w_pc_inc    = (r_pc + 1'b1) & MASK;
    w_pc_nxt    = w_redir ? w_target : (o_ram_ena && !w_halt) ? w_pc_inc : r_pc;
    w_state_nxt = (r_state == IDLE && i_start) ? (i_step_mode ? STEP : RUN) : w_halt ? HALT : r_state;
    // a served step consumes the request; extra pulses while pending are absorbed
    w_step_nxt  = r_state == STEP && !(w_fetch && !w_stall) && (r_step_pending || i_step);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_pc_plus1     <= '0;
      r_cnt          <= '0;
      r_step_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_step_pending <= w_step_nxt;
      if (o_ram_ena) begin
        r_pc_plus1 <= w_pc_inc;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign o_pc          = r_pc;
  assign o_pc_plus1    = r_pc_plus1;
  assign o_cycle_count = r_cnt;
  assign o_halted      = r_state == HALT;
endmodule

// File: tb/tb_instruction_fetch_pc.sv
// tb_instruction_fetch_pc: two depths (2048, 16) driven in lockstep and compared against a cycle reference model.
module tb_instruction_fetch_pc;
  logic clk = 0, reset = 0, i_start = 0, i_step_mode = 0, i_step = 0, i_stall = 0;
  logic i_branch_taken = 0, i_jump = 0;
  logic [31:0] i_branch_target = 0, i_jump_target = 0;
  logic hd [2];
  logic [31:0] pc [2], pp1 [2], cnt [2];
  logic ena [2], fl [2], hlt [2];
  int n_tests = 0, n_fail = 0;
  int halt_addr = -1;
  bit rnd_h = 0;
  longint dep [2] = '{2048, 16};
  int m_st [2];
  longint m_pc [2], m_pp1 [2], m_cnt [2];
  bit m_sp [2];
  always #5 clk = ~clk;
  instruction_fetch_pc #(.PC_WIDTH(32), .RAM_DEPTH(2048), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset), .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target), .i_halt_detect(hd[0]), .o_pc(pc[0]),
    .o_ram_ena(ena[0]), .o_ram_flush(fl[0]), .o_pc_plus1(pp1[0]), .o_halted(hlt[0]),
    .o_cycle_count(cnt[0]));
  instruction_fetch_pc #(.PC_WIDTH(32), .RAM_DEPTH(16), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .i_start(i_start), .i_step_mode(i_step_mode), .i_step(i_step),
    .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target), .i_halt_detect(hd[1]), .o_pc(pc[1]),
    .o_ram_ena(ena[1]), .o_ram_flush(fl[1]), .o_pc_plus1(pp1[1]), .o_halted(hlt[1]),
    .o_cycle_count(cnt[1]));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    int n_st [2];
    longint n_pc [2], n_pp1 [2], n_cnt [2];
    bit n_sp [2];
    for (int k = 0; k < 2; k++) hd[k] = (halt_addr >= 0 && m_pc[k] == halt_addr) || rnd_h;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit f, r, s, h, e;
      f = m_st[k] == 1 || (m_st[k] == 2 && m_sp[k]);
      r = f && (i_jump || i_branch_taken);
      s = f && !r && i_stall;
      h = f && !r && !i_stall && hd[k];
      e = f && !s;
      chk($sformatf("ena%0d", k), ena[k], e);
      chk($sformatf("flush%0d", k), fl[k], r);
      chk($sformatf("pc%0d", k), pc[k], m_pc[k]);
      chk($sformatf("pc_plus1_%0d", k), pp1[k], m_pp1[k]);
      chk($sformatf("cycles%0d", k), cnt[k], m_cnt[k]);
      chk($sformatf("halted%0d", k), hlt[k], m_st[k] == 3);
      n_st[k] = m_st[k]; n_pc[k] = m_pc[k]; n_pp1[k] = m_pp1[k]; n_cnt[k] = m_cnt[k]; n_sp[k] = m_sp[k];
      if (!reset) begin
        n_st[k] = 0; n_pc[k] = 0; n_pp1[k] = 0; n_cnt[k] = 0; n_sp[k] = 0;
      end else if (m_st[k] == 0) begin
        if (i_start) n_st[k] = i_step_mode ? 2 : 1;
      end else if (m_st[k] != 3) begin
        if (r) n_pc[k] = (i_jump ? longint'(i_jump_target) : longint'(i_branch_target)) % dep[k];
        else if (e && !h) n_pc[k] = (m_pc[k] + 1) % dep[k];
        if (e) begin
          n_pp1[k] = (m_pc[k] + 1) % dep[k];
          if (m_cnt[k] < 64'hFFFF_FFFF) n_cnt[k] = m_cnt[k] + 1;
        end
        if (h) n_st[k] = 3;
        if (m_st[k] == 2) n_sp[k] = (f && !s) ? 0 : (m_sp[k] || i_step);
      end
    end
    @(posedge clk);
    m_st = n_st; m_pc = n_pc; m_pp1 = n_pp1; m_cnt = n_cnt; m_sp = n_sp;
    #1;
    i_start = 0; i_step = 0; i_stall = 0; i_branch_taken = 0; i_jump = 0; rnd_h = 0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    reset = 0; ticks(2); reset = 1;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pc[k] = 0; m_pp1[k] = 0; m_cnt[k] = 0; m_sp[k] = 0;
    end
    hd[0] = 0; hd[1] = 0;
    #2;
    do_reset();
    chk("reset_pc", pc[0], 0);
    // continuous run into a halt word at address 5
    halt_addr = 5; i_start = 1; i_step_mode = 0; tick();
    ticks(10);
    chk("halt_pc", pc[0], 5);
    chk("halt_flag", hlt[0], 1);
    chk("halt_cycles", cnt[0], 6);
    i_jump = 1; i_jump_target = 40; ticks(2);
    chk("halt_ignores_jump", pc[0], 5);
    halt_addr = -1; do_reset();
    // stall three cycles at pc 2
    i_start = 1; tick(); ticks(2);
    chk("pre_stall_pc", pc[0], 2);
    for (int i = 0; i < 3; i++) begin i_stall = 1; tick(); end
    chk("stall_pc_plus1", pp1[0], 2);
    ticks(5);
    // branch beats stall and halt at pc 7
    halt_addr = 7; i_branch_taken = 1; i_branch_target = 100; i_stall = 1; tick();
    chk("branch_pc0", pc[0], 100);
    chk("branch_pc1", pc[1], 4);
    chk("branch_no_halt", hlt[0], 0);
    halt_addr = -1;
    i_jump = 1; i_jump_target = 10; i_branch_taken = 1; i_branch_target = 20; tick();
    chk("jump_wins", pc[0], 10);
    // wrap at depth 16 and target masking
    i_jump = 1; i_jump_target = 14; tick(); ticks(2);
    chk("wrap_pc1", pc[1], 0);
    i_branch_taken = 1; i_branch_target = 35; tick();
    chk("mask_pc1", pc[1], 3);
    chk("mask_pc0", pc[0], 35);
    // reset mid run at pc 9
    i_jump = 1; i_jump_target = 9; tick();
    reset = 0; tick(); reset = 1;
    chk("midreset_pc", pc[0], 0);
    i_jump = 1; i_jump_target = 30; ticks(2);
    chk("idle_ignores_jump", pc[0], 0);
    // step mode
    i_start = 1; i_step_mode = 1; tick(); ticks(3);
    chk("step_wait", pc[0], 0);
    i_step = 1; tick(); ticks(3);
    chk("step_one", pc[0], 1);
    i_step = 1; tick(); i_step = 1; tick(); ticks(3);
    chk("step_absorb", pc[0], 2);
    i_step = 1; i_stall = 1; tick(); i_stall = 1; tick(); i_stall = 1; tick();
    chk("step_stalled", pc[0], 2);
    ticks(3);
    chk("step_after_stall", pc[0], 3);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 79) != 0;
      i_start = $urandom_range(0, 5) == 0;
      i_step_mode = $urandom_range(0, 1) == 1;
      i_step = $urandom_range(0, 2) == 0;
      i_stall = $urandom_range(0, 3) == 0;
      i_branch_taken = $urandom_range(0, 7) == 0;
      i_jump = $urandom_range(0, 9) == 0;
      i_branch_target = $urandom;
      i_jump_target = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
      rnd_h = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 99) == 0) halt_addr = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
